// File: rtl/wave_record.sv
// wave_record: records signed 16-bit PCM into byte-wide sound RAM as a mono
// WAV image (44-byte RIFF header + data), then back-patches the size fields.
module wave_record #(
    parameter int unsigned MEM_BYTES = 131072
) (
    input  logic               I_CLK,
    input  logic               I_RSTn,
    input  logic [3:0]         I_H_CNT,
    input  logic [2:0]         I_CHAN,
    input  logic               I_START,
    input  logic               I_STOP,
    input  logic [2:0]         I_RATE_SEL,
    input  logic               I_BITS16,
    input  logic [16:0]        I_BASE_ADDR,
    input  logic signed [15:0] I_SND,
    output logic [16:0]        O_WR_ADDR,
    output logic [7:0]         O_WR_DATA,
    output logic               O_WR_EN,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic               O_OVERRUN,
    output logic [16:0]        O_DATA_SIZE
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_RUN, S_PATCH, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        start_prev_q;
    logic [16:0] base_q;
    logic [2:0]  rate_sel_q;
    logic        bits16_q;
    logic [11:0] div_cnt_q;
    logic [5:0]  idx_q;
    logic        stop_seen_q;
    logic [15:0] buf_q;
    logic [1:0]  buf_rem_q;
    logic [16:0] size_q;
    logic        overrun_q;
    logic        wr_en_q;
    logic [16:0] wr_addr_q;
    logic [7:0]  wr_data_q;

    logic        start_acc, slot, tick, fit_ok, issue, pending, busy_c, done_c;
    logic [31:0] rate_hz, byte_rate, need, riff_sz, data_sz;
    logic [11:0] div_val;
    logic [16:0] iss_addr;
    logic [7:0]  iss_data;

    function automatic logic [7:0] hdr_byte(input logic [5:0] idx, input logic [31:0] rate,
                                            input logic [31:0] brate, input logic b16);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            6'd0:  b = 8'h52;  6'd1:  b = 8'h49;  6'd2:  b = 8'h46;  6'd3:  b = 8'h46;
            6'd8:  b = 8'h57;  6'd9:  b = 8'h41;  6'd10: b = 8'h56;  6'd11: b = 8'h45;
            6'd12: b = 8'h66;  6'd13: b = 8'h6D;  6'd14: b = 8'h74;  6'd15: b = 8'h20;
            6'd16: b = 8'h10;  6'd20: b = 8'h01;  6'd22: b = 8'h01;
            6'd24: b = rate[7:0];   6'd25: b = rate[15:8];
            6'd26: b = rate[23:16]; 6'd27: b = rate[31:24];
            6'd28: b = brate[7:0];  6'd29: b = brate[15:8];
            6'd30: b = brate[23:16]; 6'd31: b = brate[31:24];
            6'd32: b = b16 ? 8'd2 : 8'd1;
            6'd34: b = b16 ? 8'd16 : 8'd8;
            6'd36: b = 8'h64;  6'd37: b = 8'h61;  6'd38: b = 8'h74;  6'd39: b = 8'h61;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign start_acc = I_START && !start_prev_q && (state_q == S_IDLE || state_q == S_DONE);
    assign slot      = (I_H_CNT == {I_CHAN, 1'b1});
    assign tick      = (div_cnt_q == div_val - 12'd1);
    assign need      = 32'd44 + {15'd0, size_q} + (bits16_q ? 32'd2 : 32'd1);
    assign fit_ok    = (need <= MEM_BYTES);
    assign riff_sz   = 32'd36 + {15'd0, size_q};
    assign data_sz   = {15'd0, size_q};
    // Back-to-back guard keeps the strobe single-cycle even if H_CNT stalls on our slot.
    assign issue     = slot && pending && !wr_en_q;

    // Rate, divider and byte-rate for the latched rate selection.
    always_comb begin
        rate_hz = 32'd8000;
        div_val = 12'd3000;
        case (rate_sel_q)
            3'd1: begin rate_hz = 32'd11025; div_val = 12'd2177; end
            3'd2: begin rate_hz = 32'd22050; div_val = 12'd1088; end
            3'd3: begin rate_hz = 32'd32000; div_val = 12'd750;  end
            3'd4: begin rate_hz = 32'd44100; div_val = 12'd544;  end
            3'd5: begin rate_hz = 32'd48000; div_val = 12'd500;  end
            default: begin rate_hz = 32'd8000; div_val = 12'd3000; end
        endcase
        byte_rate = bits16_q ? {rate_hz[30:0], 1'b0} : rate_hz;
    end

    // State register.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_acc) state_d = S_HDR;
            S_HDR:   if (issue && idx_q == 6'd43) state_d = (stop_seen_q || I_STOP) ? S_PATCH : S_RUN;
            S_RUN:   if (buf_rem_q == 2'd0 && (I_STOP || (tick && !fit_ok))) state_d = S_PATCH;
            S_PATCH: if (issue && idx_q == 6'd7) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs and the pending byte (address/data) for the next write slot.
    always_comb begin
        busy_c   = 1'b0;
        done_c   = 1'b0;
        pending  = 1'b0;
        iss_addr = '0;
        iss_data = '0;
        case (state_q)
            S_HDR: begin
                busy_c   = 1'b1;
                pending  = 1'b1;
                iss_addr = base_q + {11'd0, idx_q};
                iss_data = hdr_byte(idx_q, rate_hz, byte_rate, bits16_q);
            end
            S_RUN: begin
                busy_c   = 1'b1;
                pending  = (buf_rem_q != 2'd0);
                iss_addr = base_q + 17'd44 + size_q;
                if (bits16_q) iss_data = (buf_rem_q == 2'd2) ? buf_q[7:0] : buf_q[15:8];
                else          iss_data = buf_q[15:8] ^ 8'h80;
            end
            S_PATCH: begin
                busy_c   = 1'b1;
                pending  = 1'b1;
                iss_addr = base_q + (idx_q[2] ? 17'd36 : 17'd4) + {11'd0, idx_q};
                case (idx_q[1:0])
                    2'd0: iss_data = idx_q[2] ? data_sz[7:0]   : riff_sz[7:0];
                    2'd1: iss_data = idx_q[2] ? data_sz[15:8]  : riff_sz[15:8];
                    2'd2: iss_data = idx_q[2] ? data_sz[23:16] : riff_sz[23:16];
                    default: iss_data = idx_q[2] ? data_sz[31:24] : riff_sz[31:24];
                endcase
            end
            S_DONE: done_c = 1'b1;
            default: ;
        endcase
    end

    // Datapath: start latch, divider, byte counters, sample buffer and write port.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            start_prev_q <= 1'b0;
            base_q       <= '0;
            rate_sel_q   <= '0;
            bits16_q     <= 1'b0;
            div_cnt_q    <= '0;
            idx_q        <= '0;
            stop_seen_q  <= 1'b0;
            buf_q        <= '0;
            buf_rem_q    <= '0;
            size_q       <= '0;
            overrun_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            start_prev_q <= I_START;
            wr_en_q      <= issue;
            if (issue) begin
                wr_addr_q <= iss_addr;
                wr_data_q <= iss_data;
            end
            if (start_acc) begin
                base_q      <= I_BASE_ADDR;
                rate_sel_q  <= I_RATE_SEL;
                bits16_q    <= I_BITS16;
                div_cnt_q   <= '0;
                idx_q       <= '0;
                stop_seen_q <= 1'b0;
                buf_q       <= '0;
                buf_rem_q   <= '0;
                size_q      <= '0;
                overrun_q   <= 1'b0;
            end else begin
                if (state_q == S_HDR || state_q == S_RUN)
                    div_cnt_q <= tick ? '0 : div_cnt_q + 12'd1;
                case (state_q)
                    S_HDR: begin
                        if (I_STOP) stop_seen_q <= 1'b1;
                        if (issue) idx_q <= (idx_q == 6'd43) ? '0 : idx_q + 6'd1;
                    end
                    S_RUN: begin
                        if (issue) begin
                            size_q    <= size_q + 17'd1;
                            buf_rem_q <= buf_rem_q - 2'd1;
                        end
                        if (tick && !I_STOP) begin
                            if (buf_rem_q != 2'd0) overrun_q <= 1'b1;
                            else if (fit_ok) begin
                                buf_q     <= I_SND;
                                buf_rem_q <= bits16_q ? 2'd2 : 2'd1;
                            end
                        end
                    end
                    S_PATCH: if (issue) idx_q <= idx_q + 6'd1;
                    default: ;
                endcase
            end
        end
    end

    assign O_WR_ADDR   = wr_addr_q;
    assign O_WR_DATA   = wr_data_q;
    assign O_WR_EN     = wr_en_q;
    assign O_BUSY      = busy_c;
    assign O_DONE      = done_c;
    assign O_OVERRUN   = overrun_q;
    assign O_DATA_SIZE = size_q;

endmodule

// File: tb/tb_wave_record.sv
// tb_wave_record: directed bench for wave_record; RAM images are rebuilt from
// the write port and compared against hand-computed WAV field tables.
module tb_wave_record;

    logic               clk, rstn;
    logic [3:0]         hcnt;
    logic [2:0]         chan;
    logic               start1, start2, stop, freeze;
    logic [2:0]         rsel;
    logic               b16;
    logic [16:0]        base;
    logic signed [15:0] snd;

    logic [16:0] addr1, size1, addr2, size2;
    logic [7:0]  data1, data2;
    logic        wen1, busy1, done1, ovr1, wen2, busy2, done2, ovr2;

    wave_record dut1 (
        .I_CLK(clk), .I_RSTn(rstn), .I_H_CNT(hcnt), .I_CHAN(chan), .I_START(start1),
        .I_STOP(stop), .I_RATE_SEL(rsel), .I_BITS16(b16), .I_BASE_ADDR(base), .I_SND(snd),
        .O_WR_ADDR(addr1), .O_WR_DATA(data1), .O_WR_EN(wen1), .O_BUSY(busy1),
        .O_DONE(done1), .O_OVERRUN(ovr1), .O_DATA_SIZE(size1)
    );

    wave_record #(.MEM_BYTES(50)) dut2 (
        .I_CLK(clk), .I_RSTn(rstn), .I_H_CNT(hcnt), .I_CHAN(chan), .I_START(start2),
        .I_STOP(stop), .I_RATE_SEL(rsel), .I_BITS16(b16), .I_BASE_ADDR(base), .I_SND(snd),
        .O_WR_ADDR(addr2), .O_WR_DATA(data2), .O_WR_EN(wen2), .O_BUSY(busy2),
        .O_DONE(done2), .O_OVERRUN(ovr2), .O_DATA_SIZE(size2)
    );

    typedef struct {
        int          tid;
        string       name;
        int unsigned off;
        int unsigned nb;
        logic [31:0] exp;
    } fld_t;

    fld_t        tbl[$];
    int          checks, errors;
    logic [7:0]  mem1 [0:131071];
    logic [7:0]  mem2 [0:131071];
    logic [16:0] log1[$];
    logic [16:0] log2[$];
    int          b2b1, b2b2;
    logic        prev1, prev2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slot counter, free-running unless frozen
    initial begin
        hcnt = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!freeze) hcnt = hcnt + 4'd1;
        end
    end

    // RAM model for dut1
    initial begin
        for (int i = 0; i < 131072; i++) mem1[i] = 8'hEE;
        b2b1 = 0;
        prev1 = 1'b0;
        forever begin
            @(negedge clk);
            if (wen1) begin
                if (prev1) b2b1++;
                mem1[addr1] = data1;
                log1.push_back(addr1);
            end
            prev1 = wen1;
        end
    end

    // RAM model for dut2
    initial begin
        for (int i = 0; i < 131072; i++) mem2[i] = 8'hEE;
        b2b2 = 0;
        prev2 = 1'b0;
        forever begin
            @(negedge clk);
            if (wen2) begin
                if (prev2) b2b2++;
                mem2[addr2] = data2;
                log2.push_back(addr2);
            end
            prev2 = wen2;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int tid, input string name, input int unsigned off,
                       input int unsigned nb, input logic [31:0] exp);
        tbl.push_back('{tid, name, off, nb, exp});
    endtask

    task automatic add_hdr(input int tid, input logic [31:0] rate, input logic [31:0] brate,
                           input logic [31:0] align, input logic [31:0] bits,
                           input logic [31:0] riff, input logic [31:0] dsz);
        add(tid, "riff_tag",  0, 4, 32'h46464952);
        add(tid, "riff_size", 4, 4, riff);
        add(tid, "wave_tag",  8, 4, 32'h45564157);
        add(tid, "fmt_tag",  12, 4, 32'h20746D66);
        add(tid, "fmt_len",  16, 4, 32'd16);
        add(tid, "format",   20, 2, 32'd1);
        add(tid, "channels", 22, 2, 32'd1);
        add(tid, "rate",     24, 4, rate);
        add(tid, "byterate", 28, 4, brate);
        add(tid, "align",    32, 2, align);
        add(tid, "bits",     34, 2, bits);
        add(tid, "data_tag", 36, 4, 32'h61746164);
        add(tid, "data_size",40, 4, dsz);
    endtask

    function automatic logic [31:0] rd(input int sel, input logic [16:0] a, input int unsigned nb);
        logic [31:0] v;
        logic [16:0] p;
        v = '0;
        for (int unsigned k = 0; k < nb; k++) begin
            p = a + 17'(k);
            v[k*8 +: 8] = (sel == 1) ? mem1[p] : mem2[p];
        end
        return v;
    endfunction

    task automatic check_table(input int tid, input int sel, input logic [16:0] b);
        foreach (tbl[i]) begin
            if (tbl[i].tid == tid)
                chk($sformatf("t%0d_%s", tid, tbl[i].name), 64'(rd(sel, b + 17'(tbl[i].off), tbl[i].nb)),
                    64'(tbl[i].exp));
        end
    endtask

    task automatic wait_size(input int sel, input int n, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (((sel == 1) ? size1 : size2) >= 17'(n)) return;
        end
        chk("wait_size_timeout", 64'((sel == 1) ? size1 : size2), 64'(n));
    endtask

    task automatic wait_done(input int sel, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (((sel == 1) ? done1 : done2) == 1'b1) return;
        end
        chk("wait_done_timeout", 64'((sel == 1) ? done1 : done2), 64'd1);
    endtask

    task automatic wait_writes(input int n, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (log1.size() >= n) return;
        end
        chk("wait_writes_timeout", 64'(log1.size()), 64'(n));
    endtask

    task automatic pulse1();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    initial begin
        int n0, viol, tries;
        logic [16:0] pa [8];
        checks = 0; errors = 0;
        rstn = 1'b0; chan = 3'd3; start1 = 1'b0; start2 = 1'b0; stop = 1'b0; freeze = 1'b0;
        rsel = 3'd0; b16 = 1'b0; base = '0; snd = '0;

        add_hdr(1, 44100, 88200, 2, 16, 56, 20);
        add(1, "after_data", 64, 1, 32'hEE);
        add_hdr(2, 8000, 8000, 1, 8, 38, 2);
        add(2, "d0", 44, 1, 32'h00);
        add(2, "d1", 45, 1, 32'hFF);
        add(2, "after_data", 46, 1, 32'hEE);
        add_hdr(3, 44100, 88200, 2, 16, 38, 2);
        add(3, "data", 44, 2, 32'h1234);
        add(3, "after_data", 46, 1, 32'hEE);
        add_hdr(4, 44100, 88200, 2, 16, 42, 6);
        add(4, "data", 44, 4, 32'h12341234);
        add(4, "last_pair", 48, 2, 32'h1234);
        add(4, "beyond_mem", 50, 2, 32'hEEEE);
        add_hdr(6, 8000, 8000, 1, 8, 36, 0);
        add(6, "no_data", 44, 1, 32'hEE);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_dut1", {wen1, busy1, done1, ovr1, size1, addr1, data1}, 64'd0);
        chk("reset_dut2", {wen2, busy2, done2, ovr2, size2, addr2, data2}, 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 44100 Hz 16-bit, ten samples, first-write latency
        base = 17'h00100; rsel = 3'd4; b16 = 1'b1; snd = 16'shA55A;
        n0 = log1.size();
        pulse1();
        chk("s1_busy", busy1, 1);
        tries = 0;
        while (hcnt != 4'd7 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        chk("s1_no_early_write", wen1, 0);
        @(negedge clk);
        chk("s1_first_write", {wen1, addr1, data1}, {1'b1, 17'h00100, 8'h52});
        wait_size(1, 20, 20000);
        stop = 1'b1;
        wait_done(1, 2000);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        chk("s1_done_busy", {done1, busy1}, 2'b10);
        chk("s1_size", size1, 20);
        chk("s1_writes", log1.size() - n0, 72);
        check_table(1, 1, 17'h00100);
        for (int i = 0; i < 20; i++)
            chk($sformatf("s1_data%0d", i), mem1[17'h00100 + 17'd44 + 17'(i)], (i % 2 == 0) ? 8'h5A : 8'hA5);

        // 8000 Hz 8-bit, full-scale negative then positive
        base = 17'h00800; rsel = 3'd0; b16 = 1'b0; snd = 16'sh8000;
        n0 = log1.size();
        pulse1();
        wait_size(1, 1, 8000);
        snd = 16'sh7FFF;
        wait_size(1, 2, 8000);
        stop = 1'b1;
        wait_done(1, 2000);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        chk("s2_writes", log1.size() - n0, 54);
        check_table(2, 1, 17'h00800);

        // Slots stalled in RUN: overrun
        base = 17'h01000; rsel = 3'd4; b16 = 1'b1; snd = 16'sh1234;
        n0 = log1.size();
        pulse1();
        wait_writes(n0 + 44, 2000);
        freeze = 1'b1;
        repeat (2200) @(negedge clk);
        chk("s3_size_frozen", size1, 0);
        chk("s3_overrun", ovr1, 1);
        stop = 1'b1;
        freeze = 1'b0;
        wait_done(1, 2000);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        chk("s3_size", size1, 2);
        chk("s3_overrun_sticky", ovr1, 1);
        chk("s3_writes", log1.size() - n0, 54);
        check_table(3, 1, 17'h01000);

        // MEM_BYTES=50 instance
        base = 17'h00200; rsel = 3'd4; b16 = 1'b1; snd = 16'sh1234;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done(2, 8000);
        repeat (2) @(negedge clk);
        chk("s4_size", size2, 6);
        chk("s4_writes", log2.size(), 58);
        viol = 0;
        foreach (log2[i]) if (log2[i] >= 17'h00200 + 17'd50) viol++;
        chk("s4_window", viol, 0);
        check_table(4, 2, 17'h00200);
        chk("s4_b2b", b2b2, 0);

        // Start from DONE clears overrun; reset mid-RUN aborts
        base = 17'h02000; rsel = 3'd4; b16 = 1'b1;
        pulse1();
        chk("s5_start_flags", {busy1, done1, ovr1, size1}, {3'b100, 17'd0});
        wait_size(1, 2, 4000);
        rstn = 1'b0;
        #1;
        chk("s5_async_reset", {wen1, busy1, done1, ovr1, size1, addr1, data1}, 64'd0);
        @(negedge clk);
        chk("s5_reset_next", {wen1, busy1, done1, ovr1, size1, addr1, data1}, 64'd0);
        rstn = 1'b1;
        n0 = log1.size();
        repeat (300) @(negedge clk);
        chk("s5_no_writes", log1.size() - n0, 0);
        chk("s5_idle", {busy1, done1}, 2'b00);
        chk("s5_no_patch", {mem1[17'h02004], mem1[17'h02028]}, 16'h0000);

        // Extra start during HDR ignored; stop during HDR gives empty recording
        base = 17'h03000; rsel = 3'd0; b16 = 1'b0;
        n0 = log1.size();
        pulse1();
        wait_writes(n0 + 5, 200);
        pulse1();
        stop = 1'b1;
        wait_done(1, 3000);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        chk("s6_writes", log1.size() - n0, 52);
        chk("s6_size", size1, 0);
        pa = '{17'h03004, 17'h03005, 17'h03006, 17'h03007, 17'h03028, 17'h03029, 17'h0302A, 17'h0302B};
        for (int k = 0; k < 8; k++)
            if (n0 + 44 + k < log1.size())
                chk($sformatf("s6_patch_addr%0d", k), log1[n0 + 44 + k], pa[k]);
        check_table(6, 1, 17'h03000);
        chk("b2b_dut1", b2b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
